// File: rtl/mcycle_control32.sv
// Multi-cycle MIPS32 control unit: IF/ID/EX/MEM/WB sequencer with memory versus IO split in MEM.
// Optional IO wait abandonment is compiled in by defining CTRL_IO_TIMEOUT_EN.
module mcycle_control32 #(
  parameter int                     ADDR_HIGH_W = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_HIGH     = {ADDR_HIGH_W{1'b1}},
  parameter int                     IO_TIMEOUT  = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Function_opcode,
  input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
  input  logic                   io_ready,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IORead,
  output logic                   IOWrite,
  output logic                   MemorIOtoReg,
  output logic                   RegDST,
  output logic                   ALUSrc,
  output logic                   I_format,
  output logic                   Sftmd,
  output logic                   Jrn,
  output logic                   Jmp,
  output logic                   Jal,
  output logic                   Branch,
  output logic                   nBranch,
  output logic [1:0]             ALUOp,
  output logic                   instr_done,
  output logic                   illegal_instr,
  output logic                   io_timeout
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic r_format_s, lw_s, sw_s, legal_s, mem_io_s, timeout_s;
  logic pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;
  logic io_read_s, io_write_s, mem_to_reg_s, done_s, illegal_s;

  always_comb begin
    r_format_s = (Opcode == OP_RTYPE);
    lw_s       = (Opcode == OP_LW);
    sw_s       = (Opcode == OP_SW);
    I_format   = (Opcode[5:3] == 3'b001);
    Jmp        = (Opcode == OP_J);
    Jal        = (Opcode == OP_JAL);
    Branch     = (Opcode == OP_BEQ);
    nBranch    = (Opcode == OP_BNE);
    Jrn        = r_format_s && (Function_opcode == FN_JR);
    Sftmd      = r_format_s && (Function_opcode[5:3] == 3'b000);
    RegDST     = r_format_s;
    ALUSrc     = I_format || lw_s || sw_s;
    ALUOp      = {r_format_s || I_format, Branch || nBranch};
    legal_s    = r_format_s || I_format || lw_s || sw_s || Branch || nBranch || Jmp || Jal;
    mem_io_s   = (Alu_resultHigh == IO_HIGH);
  end

`ifdef CTRL_IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  logic [CNT_W-1:0] io_cnt_q, io_cnt_d;

  // Count unanswered IO cycles; any non-MEM state leaves the count at zero for the next entry.
  always_comb begin
    if ((state_q == S_MEM) && mem_io_s && !io_ready) begin
      io_cnt_d = io_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      io_cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_cnt_q <= {CNT_W{1'b0}};
    end else begin
      io_cnt_q <= io_cnt_d;
    end
  end

  assign timeout_s = (state_q == S_MEM) && mem_io_s && !io_ready &&
                     (io_cnt_q == CNT_W'(IO_TIMEOUT - 1));
`else
  // Waits forever; evaluates to 0 for any legal IO_TIMEOUT.
  assign timeout_s = (IO_TIMEOUT < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (!legal_s || Jmp || Jal || Jrn) state_d = S_IF;
        else                               state_d = S_EX;
      end
      S_EX: begin
        if (lw_s || sw_s)            state_d = S_MEM;
        else if (Branch || nBranch)  state_d = S_IF;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (mem_io_s && !io_ready) state_d = timeout_s ? S_IF : S_MEM;
        else if (lw_s)             state_d = S_WB;
        else                       state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    io_read_s    = 1'b0;
    io_write_s   = 1'b0;
    mem_to_reg_s = 1'b0;
    done_s       = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
      end
      S_ID: begin
        if (!legal_s) begin
          illegal_s = 1'b1;
        end else if (Jmp || Jal || Jrn) begin
          pc_write_s  = 1'b1;
          reg_write_s = Jal;
          done_s      = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      S_EX: begin
        if (Branch || nBranch) begin
          pc_write_s = 1'b1;
          done_s     = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      S_MEM: begin
        // IO strobes hold until io_ready; a store finishes here, a load continues to WB.
        if (mem_io_s) begin
          io_read_s  = lw_s && !timeout_s;
          io_write_s = sw_s && !timeout_s;
          done_s     = sw_s && io_ready;
        end else begin
          mem_read_s  = lw_s;
          mem_write_s = sw_s;
          done_s      = sw_s;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = lw_s;
        done_s       = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign PCWrite       = pc_write_s   & ~reset;
  assign IRWrite       = ir_write_s   & ~reset;
  assign RegWrite      = reg_write_s  & ~reset;
  assign MemRead       = mem_read_s   & ~reset;
  assign MemWrite      = mem_write_s  & ~reset;
  assign IORead        = io_read_s    & ~reset;
  assign IOWrite       = io_write_s   & ~reset;
  assign MemorIOtoReg  = mem_to_reg_s & ~reset;
  assign instr_done    = done_s       & ~reset;
  assign illegal_instr = illegal_s    & ~reset;
  assign io_timeout    = timeout_s    & ~reset;

endmodule
